// File: rtl/mdio_pkg.sv
// Shared types and constants for the MDIO link-status poller.
// State encoding is fixed so debug captures and checkers decode it the same way.
package mdio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BUSY  = 3'd2,
        ST_EVAL  = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    localparam int TIMEOUT_CNT_W = 8;
    // Debounce run counters saturate at 15, the largest UP_CNT/DOWN_CNT allowed.
    localparam int RUN_W = 4;

    function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] run);
        return (run == {RUN_W{1'b1}}) ? run : run + RUN_W'(1);
    endfunction

endpackage

// File: rtl/mdio_link_monitor_if.sv
// Trigger/completion bus between the link poller and the mdio_set transaction engine.
interface mdio_link_monitor_if;
    // Handshake: the master raises mdio_set_start_flag for exactly one cycle to start a
    // transaction; the slave answers with a one-cycle mdio_set_end_flag, and mdio_link_flag
    // is meaningful only in that cycle. At most one transaction is outstanding at a time.
    logic mdio_set_start_flag;
    logic mdio_set_end_flag;
    logic mdio_link_flag;

    modport master (
        output mdio_set_start_flag,
        input  mdio_set_end_flag,
        input  mdio_link_flag
    );

    modport slave (
        input  mdio_set_start_flag,
        output mdio_set_end_flag,
        output mdio_link_flag
    );
endinterface

// File: rtl/mdio_link_debounce.sv
// Turns per-poll link samples into a stable link level using separate up/down run lengths.
module mdio_link_debounce
    import mdio_pkg::*;
#(
    parameter int unsigned UP_CNT   = 2,
    parameter int unsigned DOWN_CNT = 3
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic sample_valid,
    input  logic sample,
    output logic link_up,
    output logic link_change
);

    logic [RUN_W-1:0] up_run;
    logic [RUN_W-1:0] down_run;
    logic [RUN_W-1:0] up_nxt;
    logic [RUN_W-1:0] down_nxt;

    always_comb begin
        up_nxt   = run_inc(up_run);
        down_nxt = run_inc(down_run);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            up_run      <= '0;
            down_run    <= '0;
            link_up     <= 1'b0;
            link_change <= 1'b0;
        end else begin
            link_change <= 1'b0;
            if (sample_valid) begin
                if (sample) begin
                    down_run <= '0;
                    up_run   <= up_nxt;
                    if (!link_up && (up_nxt >= RUN_W'(UP_CNT))) begin
                        link_up     <= 1'b1;
                        link_change <= 1'b1;
                    end
                end else begin
                    up_run   <= '0;
                    down_run <= down_nxt;
                    if (link_up && (down_nxt >= RUN_W'(DOWN_CNT))) begin
                        link_up     <= 1'b0;
                        link_change <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mdio_link_monitor.sv
// Periodic PHY link poller: triggers mdio_set, times out stuck polls, debounces link state.
module mdio_link_monitor
    import mdio_pkg::*;
#(
    parameter int unsigned POLL_PERIOD = 50_000_000,
    parameter int unsigned TIMEOUT     = 100_000,
    parameter int unsigned UP_CNT      = 2,
    parameter int unsigned DOWN_CNT    = 3
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     enable,
    input  logic                     poll_now,
    mdio_link_monitor_if.master      mdio,
    output logic                     link_up,
    output logic                     link_change,
    output logic                     poll_timeout,
    output logic [TIMEOUT_CNT_W-1:0] timeout_cnt,
    output state_t                   state_dbg
);

    localparam int PER_W = $clog2(POLL_PERIOD);
    localparam int TO_W  = $clog2(TIMEOUT);

    state_t           state;
    logic             start_q;
    logic             sample;
    logic [PER_W-1:0] per_cnt;
    logic [TO_W-1:0]  busy_cnt;

    assign mdio.mdio_set_start_flag = start_q;
    assign state_dbg                = state;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= ST_IDLE;
            start_q      <= 1'b0;
            sample       <= 1'b0;
            per_cnt      <= '0;
            busy_cnt     <= '0;
            poll_timeout <= 1'b0;
            timeout_cnt  <= '0;
        end else begin
            start_q      <= 1'b0;
            poll_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state   <= ST_START;
                        start_q <= 1'b1;
                    end
                end
                ST_START: begin
                    busy_cnt <= '0;
                    state    <= ST_BUSY;
                end
                // A real completion on the terminal count takes priority over the timeout.
                ST_BUSY: begin
                    if (mdio.mdio_set_end_flag) begin
                        sample <= mdio.mdio_link_flag;
                        state  <= ST_EVAL;
                    end else if (busy_cnt == TO_W'(TIMEOUT - 1)) begin
                        sample       <= 1'b0;
                        poll_timeout <= 1'b1;
                        if (timeout_cnt != {TIMEOUT_CNT_W{1'b1}})
                            timeout_cnt <= timeout_cnt + TIMEOUT_CNT_W'(1);
                        state <= ST_EVAL;
                    end else begin
                        busy_cnt <= busy_cnt + TO_W'(1);
                    end
                end
                ST_EVAL: begin
                    per_cnt <= '0;
                    state   <= enable ? ST_WAIT : ST_IDLE;
                end
                ST_WAIT: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (poll_now || (per_cnt == PER_W'(POLL_PERIOD - 1))) begin
                        state   <= ST_START;
                        start_q <= 1'b1;
                    end else begin
                        per_cnt <= per_cnt + PER_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mdio_link_debounce #(
        .UP_CNT   (UP_CNT),
        .DOWN_CNT (DOWN_CNT)
    ) u_debounce (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .sample_valid (state == ST_EVAL),
        .sample       (sample),
        .link_up      (link_up),
        .link_change  (link_change)
    );

endmodule
